pipeline_controller: RTL

- Central stall/flush sequencer for the 5-stage ARM pipeline. It combines three inputs: the hazard-unit stall, branch-taken from EXE, and multi-cycle data-memory accesses from MEM.
- It produces the IF-stage freeze and branch-select controls, the ID/EXE bubble, the pipeline flush and the global freeze.
- It keeps saturating performance counters for stall cycles and flushes.
- Sits beside the datapath; all pipeline registers and the IF PC register take their hold/clear controls from this block.

---
 rtl/pipeline_controller_if.sv | 26 ++
 rtl/pipeline_controller.sv | 70 +++++++
 2 files changed

// File: rtl/pipeline_controller_if.sv
// pipeline_controller_if: hazard/branch/memory controls into the sequencer and its stall/flush outputs
interface pipeline_controller_if #(parameter int CNT_W = 16);
    logic             hazard;
    logic             branch_taken;
    logic             mem_req;
    logic             cnt_clr;
    logic             if_freeze;
    logic             if_branch_taken;
    logic             id_bubble;
    logic             flush;
    logic             freeze_all;
    logic             mem_en;
    logic             mem_ready;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    modport master (
        output hazard, branch_taken, mem_req, cnt_clr,
        input  if_freeze, if_branch_taken, id_bubble, flush, freeze_all,
               mem_en, mem_ready, stall_count, flush_count
    );
    modport slave (
        input  hazard, branch_taken, mem_req, cnt_clr,
        output if_freeze, if_branch_taken, id_bubble, flush, freeze_all,
               mem_en, mem_ready, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/flush sequencer with memory-wait freeze and saturating perf counters
module pipeline_controller #(
    parameter int MEM_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input logic                 clk,
    input logic                 rst,
    pipeline_controller_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    state_t           state;
    logic [7:0]       wcnt;
    logic             ready_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             fz;
    logic             if_fz;
    logic             fl;
    // Freeze covers the request cycle in IDLE plus every wait cycle; a branch is deferred while frozen
    always_comb begin
        fz    = (state == S_WAIT) | ((state == S_IDLE) & bus.mem_req);
        if_fz = fz | (bus.hazard & ~bus.branch_taken);
        fl    = bus.branch_taken & ~fz;
    end
    assign bus.freeze_all      = fz;
    assign bus.mem_en          = fz;
    assign bus.if_freeze       = if_fz;
    assign bus.if_branch_taken = fl;
    assign bus.flush           = fl;
    assign bus.id_bubble       = bus.hazard & ~bus.branch_taken & ~fz;
    assign bus.mem_ready       = ready_q;
    assign bus.stall_count     = stall_q;
    assign bus.flush_count     = flush_q;
    // Access sequencer; mem_ready is registered alongside the entry into S_DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                S_IDLE: if (bus.mem_req) begin
                    wcnt  <= 8'(MEM_WAIT - 1);
                    state <= S_WAIT;
                end
                S_WAIT: if (wcnt == 8'd0) begin
                    state   <= S_DONE;
                    ready_q <= 1'b1;
                end else begin
                    wcnt <= wcnt - 8'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    // Saturating counters; clear wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (bus.cnt_clr) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (if_fz && !(&stall_q)) stall_q <= stall_q + 1'b1;
            if (fl && !(&flush_q)) flush_q <= flush_q + 1'b1;
        end
    end
endmodule
